// File: rtl/apb_uart_fifo.sv
// APB UART: 8N1 TX/RX, programmable divisor, TX/RX FIFOs, sticky errors, level IRQ.
// Ports: APB slave (PCLK, PRESET, PSEL, PENABLE, PWRITE, PADDR, PWDATA,
//   PRDATA, PREADY, PSLVERR), serial RX in / TX out, IRQ out.

module uart_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_flush,
    input  logic       i_push,
    input  logic       i_pop,
    input  logic [7:0] i_wdata,
    output logic [7:0] o_rdata,
    output logic       o_empty,
    output logic       o_full,
    output logic       o_drop
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW:0] r_wp;
    logic [AW:0] r_rp;
    logic        w_push;
    logic        w_pop;

    assign o_empty = (r_wp == r_rp);
    assign o_full  = (r_wp[AW] != r_rp[AW]) &&
                     (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign w_pop   = i_pop & ~o_empty;
    // a pop frees the slot, so a full FIFO still accepts a same-cycle push
    assign w_push  = i_push & (~o_full | w_pop);
    assign o_drop  = i_push & ~w_push;
    assign o_rdata = r_mem[r_rp[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wp[AW-1:0]] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
        end
    end
endmodule

module apb_uart_fifo #(
    parameter int TX_DEPTH  = 8,
    parameter int RX_DEPTH  = 8,
    parameter int DIV_W     = 16,
    parameter int DIV_RESET = 433
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [4:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    input  logic        RX,
    output logic        TX,
    output logic        IRQ
);
    typedef enum logic [1:0] {
        TX_IDLE, TX_START, TX_DATA, TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_state_t;

    // ---------------- APB decode ----------------
    logic       w_acc;
    logic       w_wr;
    logic       w_rd;
    logic [2:0] w_idx;
    logic       w_unused;

    assign w_acc    = PSEL & PENABLE;
    assign w_wr     = w_acc & PWRITE;
    assign w_rd     = w_acc & ~PWRITE;
    assign w_idx    = PADDR[4:2];
    assign w_unused = ^{PADDR, PWDATA};
    assign PREADY   = 1'b1;
    assign PSLVERR  = w_acc & (w_idx > 3'd4);

    logic w_wr_data;
    logic w_wr_ctrl;
    logic w_wr_baud;
    logic w_wr_irq;
    logic w_rd_data;

    assign w_wr_data = w_wr & (w_idx == 3'd0);
    assign w_wr_ctrl = w_wr & (w_idx == 3'd2);
    assign w_wr_baud = w_wr & (w_idx == 3'd3);
    assign w_wr_irq  = w_wr & (w_idx == 3'd4);
    assign w_rd_data = w_rd & (w_idx == 3'd0);

    // ---------------- control registers ----------------
    logic             r_txen;
    logic             r_rxen;
    logic             r_lb;
    logic [DIV_W-1:0] r_div;
    logic [2:0]       r_ien;
    logic             r_fe;
    logic             r_ovr;
    logic             r_txovf;
    logic             r_irq;
    logic [DIV_W-1:0] w_div_eff;

    assign w_div_eff = (r_div < DIV_W'(3)) ? DIV_W'(3) : r_div;

    // ---------------- FIFOs ----------------
    logic       w_tx_empty;
    logic       w_tx_full;
    logic       w_tx_drop;
    logic [7:0] w_tx_head;
    logic       w_tx_pop;
    logic       w_rx_empty;
    logic       w_rx_full;
    logic       w_rx_drop;
    logic [7:0] w_rx_head;
    logic       w_rx_push;
    logic [7:0] r_rx_sh;

    uart_fifo #(.DEPTH(TX_DEPTH)) u_txf (
        .i_clk   (PCLK),
        .i_rst   (PRESET),
        .i_flush (w_wr_ctrl & PWDATA[3]),
        .i_push  (w_wr_data),
        .i_pop   (w_tx_pop),
        .i_wdata (PWDATA[7:0]),
        .o_rdata (w_tx_head),
        .o_empty (w_tx_empty),
        .o_full  (w_tx_full),
        .o_drop  (w_tx_drop)
    );

    uart_fifo #(.DEPTH(RX_DEPTH)) u_rxf (
        .i_clk   (PCLK),
        .i_rst   (PRESET),
        .i_flush (w_wr_ctrl & PWDATA[4]),
        .i_push  (w_rx_push),
        .i_pop   (w_rd_data),
        .i_wdata (r_rx_sh),
        .o_rdata (w_rx_head),
        .o_empty (w_rx_empty),
        .o_full  (w_rx_full),
        .o_drop  (w_rx_drop)
    );

    // ---------------- TX path ----------------
    tx_state_t        r_tx_st;
    tx_state_t        w_tx_nst;
    logic [DIV_W-1:0] r_tx_cnt;
    logic [2:0]       r_tx_bit;
    logic [7:0]       r_tx_sh;
    logic             r_tx;
    logic             w_tx_tick;
    logic             w_tx_reload;
    logic             w_tx_shift;
    logic             w_tx_out;

    assign w_tx_tick = (r_tx_cnt == '0);

    always_comb begin
        w_tx_nst    = r_tx_st;
        w_tx_pop    = 1'b0;
        w_tx_reload = 1'b0;
        w_tx_shift  = 1'b0;
        w_tx_out    = 1'b1;
        unique case (r_tx_st)
            TX_IDLE: begin
                if (r_txen && !w_tx_empty) begin
                    w_tx_nst    = TX_START;
                    w_tx_pop    = 1'b1;
                    w_tx_reload = 1'b1;
                end
            end
            TX_START: begin
                w_tx_out = 1'b0;
                if (w_tx_tick) begin
                    w_tx_nst    = TX_DATA;
                    w_tx_reload = 1'b1;
                end
            end
            TX_DATA: begin
                w_tx_out = r_tx_sh[0];
                if (w_tx_tick) begin
                    w_tx_shift  = 1'b1;
                    w_tx_reload = 1'b1;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_nst = TX_STOP;
                    end
                end
            end
            TX_STOP: begin
                if (w_tx_tick) begin
                    // chain straight into the next start bit: no idle gap
                    if (r_txen && !w_tx_empty) begin
                        w_tx_nst    = TX_START;
                        w_tx_pop    = 1'b1;
                        w_tx_reload = 1'b1;
                    end else begin
                        w_tx_nst = TX_IDLE;
                    end
                end
            end
            default: w_tx_nst = TX_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_tx_st  <= TX_IDLE;
            r_tx_cnt <= '0;
            r_tx_bit <= '0;
            r_tx_sh  <= '0;
            r_tx     <= 1'b1;
        end else begin
            r_tx_st <= w_tx_nst;
            r_tx    <= w_tx_out;
            if (w_tx_reload) begin
                r_tx_cnt <= w_div_eff;
            end else if (!w_tx_tick) begin
                r_tx_cnt <= r_tx_cnt - DIV_W'(1);
            end
            if (w_tx_pop) begin
                r_tx_sh  <= w_tx_head;
                r_tx_bit <= '0;
            end else if (w_tx_shift) begin
                r_tx_sh  <= {1'b0, r_tx_sh[7:1]};
                r_tx_bit <= r_tx_bit + 3'd1;
            end
        end
    end

    assign TX = r_tx;

    // ---------------- RX path ----------------
    rx_state_t        r_rx_st;
    rx_state_t        w_rx_nst;
    logic [DIV_W-1:0] r_rx_cnt;
    logic [2:0]       r_rx_bit;
    logic             r_rx_s1;
    logic             r_rx_s2;
    logic             r_rx_d;
    logic             w_rx_src;
    logic             w_rx_fall;
    logic             w_rx_tick;
    logic             w_rx_half;
    logic             w_rx_reload;
    logic             w_rx_shift;
    logic             w_rx_done;
    logic             w_fe_set;

    assign w_rx_src  = r_lb ? r_tx : RX;
    assign w_rx_fall = r_rx_d & ~r_rx_s2;
    assign w_rx_tick = (r_rx_cnt == '0);
    assign w_rx_push = w_rx_done & r_rx_s2;
    assign w_fe_set  = w_rx_done & ~r_rx_s2;

    always_comb begin
        w_rx_nst    = r_rx_st;
        w_rx_half   = 1'b0;
        w_rx_reload = 1'b0;
        w_rx_shift  = 1'b0;
        w_rx_done   = 1'b0;
        unique case (r_rx_st)
            RX_IDLE: begin
                if (r_rxen && w_rx_fall) begin
                    w_rx_nst  = RX_START;
                    w_rx_half = 1'b1;
                end
            end
            RX_START: begin
                // line must still be low mid start bit, else a glitch
                if (w_rx_tick) begin
                    if (!r_rx_s2) begin
                        w_rx_nst    = RX_DATA;
                        w_rx_reload = 1'b1;
                    end else begin
                        w_rx_nst = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (w_rx_tick) begin
                    w_rx_shift  = 1'b1;
                    w_rx_reload = 1'b1;
                    if (r_rx_bit == 3'd7) begin
                        w_rx_nst = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (w_rx_tick) begin
                    w_rx_done = 1'b1;
                    w_rx_nst  = RX_IDLE;
                end
            end
            default: w_rx_nst = RX_IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_rx_s1  <= 1'b1;
            r_rx_s2  <= 1'b1;
            r_rx_d   <= 1'b1;
            r_rx_st  <= RX_IDLE;
            r_rx_cnt <= '0;
            r_rx_bit <= '0;
            r_rx_sh  <= '0;
        end else begin
            r_rx_s1 <= w_rx_src;
            r_rx_s2 <= r_rx_s1;
            r_rx_d  <= r_rx_s2;
            r_rx_st <= w_rx_nst;
            if (w_rx_half) begin
                r_rx_cnt <= w_div_eff >> 1;
            end else if (w_rx_reload) begin
                r_rx_cnt <= w_div_eff;
            end else if (!w_rx_tick) begin
                r_rx_cnt <= r_rx_cnt - DIV_W'(1);
            end
            if (w_rx_half) begin
                r_rx_bit <= '0;
            end else if (w_rx_shift) begin
                r_rx_bit <= r_rx_bit + 3'd1;
                r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
            end
        end
    end

    // ---------------- registers, flags, IRQ ----------------
    logic w_clr;

    assign w_clr = w_wr_irq & PWDATA[8];

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_txen  <= 1'b0;
            r_rxen  <= 1'b0;
            r_lb    <= 1'b0;
            r_div   <= DIV_W'(DIV_RESET);
            r_ien   <= '0;
            r_fe    <= 1'b0;
            r_ovr   <= 1'b0;
            r_txovf <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_txen <= PWDATA[0];
                r_rxen <= PWDATA[1];
                r_lb   <= PWDATA[2];
            end
            if (w_wr_baud) begin
                r_div <= PWDATA[DIV_W-1:0];
            end
            if (w_wr_irq) begin
                r_ien <= PWDATA[2:0];
            end
            // a new error in the clearing cycle survives the clear
            r_fe    <= (r_fe & ~w_clr) | w_fe_set;
            r_ovr   <= (r_ovr & ~w_clr) | w_rx_drop;
            r_txovf <= (r_txovf & ~w_clr) | w_tx_drop;
            r_irq   <= (r_ien[0] & ~w_rx_empty) |
                       (r_ien[1] & w_tx_empty & r_txen) |
                       (r_ien[2] & (r_fe | r_ovr | r_txovf));
        end
    end

    assign IRQ = r_irq;

    logic [7:0] w_status;
    logic       w_tx_busy;

    assign w_tx_busy = ~w_tx_empty | (r_tx_st != TX_IDLE);
    assign w_status  = {r_txovf, r_ovr, r_fe, w_tx_busy,
                        w_rx_full, ~w_rx_empty, w_tx_full, w_tx_empty};

    always_comb begin
        PRDATA = '0;
        if (w_rd) begin
            case (w_idx)
                3'd0: PRDATA = w_rx_empty ? 32'd0 : {24'd0, w_rx_head};
                3'd1: PRDATA = {24'd0, w_status};
                3'd2: PRDATA = {29'd0, r_lb, r_rxen, r_txen};
                3'd3: PRDATA = 32'(r_div);
                3'd4: PRDATA = {29'd0, r_ien};
                default: PRDATA = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_apb_uart_fifo.sv
// Directed testbench for apb_uart_fifo.
// Linear APB/serial stimulus with immediate-assertion checks.

module tb_apb_uart_fifo;
    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [4:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic        RX;
    logic        TX;
    logic        IRQ;

    int n_cmp = 0;
    int n_bad = 0;

    apb_uart_fifo dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR),
        .RX      (RX),
        .TX      (TX),
        .IRQ     (IRQ)
    );

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic apb_write(input logic [4:0] a, input logic [31:0] d);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1;
        PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [4:0] a,
                            output logic [31:0] d,
                            output logic e);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = a;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        d = PRDATA;
        e = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    // 8N1 frame on RX, 8 cycles per bit (DIV=7)
    task automatic rx_frame(input logic [7:0] d, input logic stp);
        logic [9:0] fr;
        fr = {stp, d, 1'b0};
        @(posedge PCLK); #1;
        for (int i = 0; i < 10; i++) begin
            RX = fr[i];
            repeat (8) @(posedge PCLK);
            #1;
        end
        RX = 1'b1;
        repeat (4) @(posedge PCLK);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        logic [9:0]  fr;
        int          k;

        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; RX = 1'b1;
        repeat (3) @(posedge PCLK);
        #1 PRESET = 1'b0;

        // reset state
        @(negedge PCLK);
        check("rst_tx", {31'd0, TX}, 32'd1);
        check("rst_irq", {31'd0, IRQ}, 32'd0);
        check("rst_prdata", PRDATA, 32'd0);
        check("rst_pready", {31'd0, PREADY}, 32'd1);
        apb_read(5'h04, rd, er);
        check("rst_status", rd, 32'h01);
        check("rst_slverr", {31'd0, er}, 32'd0);
        apb_read(5'h0C, rd, er);
        check("rst_baud", rd, 32'd433);

        // TX frame of 0xA5 with DIV=3
        apb_write(5'h0C, 32'd3);
        apb_write(5'h08, 32'h1);
        apb_write(5'h00, 32'hA5);
        fr = {1'b1, 8'hA5, 1'b0};
        repeat (2) @(posedge PCLK);
        for (int i = 0; i < 40; i++) begin
            @(negedge PCLK);
            check($sformatf("tx_cyc%0d", i), {31'd0, TX}, {31'd0, fr[i/4]});
        end
        @(negedge PCLK);
        check("tx_idle_after", {31'd0, TX}, 32'd1);
        apb_read(5'h04, rd, er);
        check("tx_status_done", rd, 32'h01);

        // loopback two bytes, DIV=7, RX nonempty IRQ
        apb_write(5'h0C, 32'd7);
        apb_write(5'h10, 32'h1);
        apb_write(5'h08, 32'h7);
        apb_write(5'h00, 32'h3C);
        apb_write(5'h00, 32'hC3);
        repeat (40) @(posedge PCLK);
        @(negedge PCLK);
        check("lb_irq_early", {31'd0, IRQ}, 32'd0);
        k = 0;
        while (IRQ !== 1'b1 && k < 200) begin
            @(negedge PCLK);
            k++;
        end
        check("lb_irq_set", {31'd0, IRQ}, 32'd1);
        apb_read(5'h04, rd, er);
        check("lb_rxne", {31'd0, rd[2]}, 32'd1);
        repeat (120) @(posedge PCLK);
        apb_read(5'h00, rd, er);
        check("lb_byte0", rd, 32'h3C);
        apb_read(5'h00, rd, er);
        check("lb_byte1", rd, 32'hC3);
        apb_read(5'h04, rd, er);
        check("lb_status_end", rd, 32'h01);
        apb_read(5'h00, rd, er);
        check("lb_empty_read", rd, 32'h0);
        @(negedge PCLK);
        check("lb_irq_clear", {31'd0, IRQ}, 32'd0);
        apb_write(5'h10, 32'h0);
        apb_write(5'h08, 32'h0);

        // TX overflow with TXEN=0, then drain through loopback
        apb_write(5'h0C, 32'd3);
        for (int i = 0; i < 9; i++) begin
            apb_write(5'h00, 32'h10 + i);
        end
        apb_read(5'h04, rd, er);
        check("ovf_status", rd, 32'h92);
        apb_write(5'h10, 32'h100);
        apb_read(5'h04, rd, er);
        check("ovf_cleared", rd, 32'h12);
        apb_write(5'h08, 32'h7);
        repeat (400) @(posedge PCLK);
        apb_read(5'h04, rd, er);
        check("ovf_drained", rd, 32'h0D);
        for (int i = 0; i < 8; i++) begin
            apb_read(5'h00, rd, er);
            check($sformatf("ovf_byte%0d", i), rd, 32'h10 + i);
        end
        apb_read(5'h04, rd, er);
        check("ovf_no_extra", rd, 32'h01);
        apb_write(5'h08, 32'h0);

        // framing error on external RX
        apb_write(5'h0C, 32'd7);
        apb_write(5'h08, 32'h2);
        rx_frame(8'h55, 1'b0);
        repeat (10) @(posedge PCLK);
        apb_read(5'h04, rd, er);
        check("fe_status", rd, 32'h21);
        apb_write(5'h10, 32'h100);
        apb_read(5'h04, rd, er);
        check("fe_cleared", rd, 32'h01);

        // RX overrun: RX_DEPTH+1 frames
        for (int i = 0; i < 9; i++) begin
            rx_frame(8'h80 + 8'(i), 1'b1);
        end
        repeat (20) @(posedge PCLK);
        apb_read(5'h04, rd, er);
        check("ovr_status", rd, 32'h4D);
        for (int i = 0; i < 8; i++) begin
            apb_read(5'h00, rd, er);
            check($sformatf("ovr_byte%0d", i), rd, 32'h80 + i);
        end
        apb_read(5'h04, rd, er);
        check("ovr_sticky", rd, 32'h41);
        apb_write(5'h10, 32'h100);

        // glitch of a quarter bit period
        @(posedge PCLK); #1;
        RX = 1'b0;
        repeat (2) @(posedge PCLK);
        #1 RX = 1'b1;
        repeat (30) @(posedge PCLK);
        apb_read(5'h04, rd, er);
        check("glitch_status", rd, 32'h01);
        rx_frame(8'h5A, 1'b1);
        repeat (10) @(posedge PCLK);
        apb_read(5'h00, rd, er);
        check("glitch_recover", rd, 32'h5A);

        // unmapped address
        apb_read(5'h14, rd, er);
        check("unmap_prdata", rd, 32'h0);
        check("unmap_slverr", {31'd0, er}, 32'd1);
        apb_read(5'h08, rd, er);
        check("map_slverr", {31'd0, er}, 32'd0);
        check("ctrl_read", rd, 32'h2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/apb_uart_fifo.md
# apb_uart_fifo

Parametrised APB UART peripheral: 8N1 serial TX/RX with programmable baud divisor, TX and RX FIFOs of configurable depth, sticky error flags and a maskable level interrupt. It sits on the SoC APB bus next to the other slaves and replaces the fixed-baud, unbuffered UART slave. All serial timing derives from PCLK via a software-set divisor, so there is no clock-enable input.

## Interface
- TX_DEPTH, 8, TX FIFO entries (power of two, ≥2)
- RX_DEPTH, 8, RX FIFO entries (power of two, ≥2)
- DIV_W, 16, baud divisor register width
- DIV_RESET, 433, divisor reset value (115200 baud at 50 MHz: bit period = DIV+1 cycles)

- PCLK  in  1  system clock; all logic on rising edge
- PRESET  in  1  synchronous, active-high reset
- PSEL  in  1  APB select
- PENABLE  in  1  APB access phase
- PWRITE  in  1  1 = write
- PADDR  in  5  byte address; bits [1:0] ignored
- PWDATA  in  32  write data
- PRDATA  out  32  read data, zero in unused bits and when not selected
- PREADY  out  1  tied 1 (zero wait state)
- PSLVERR  out  1  1 during access phase to unmapped address
- RX  in  1  serial input, asynchronous, idle high
- TX  out  1  serial output, idle high
- IRQ  out  1  level interrupt

## Operation
- Register map (word offsets):
  - 0x00 DATA: write pushes PWDATA[7:0] to TX FIFO (dropped if full, TXOVF set); read returns RX head and pops (returns 0, no pop, if empty).
  - 0x04 STATUS (RO): [0] TX empty, [1] TX full, [2] RX nonempty, [3] RX full, [4] TX busy (FIFO nonempty or shifter active), [5] framing error, [6] RX overrun, [7] TXOVF.
  - 0x08 CTRL: [0] TXEN, [1] RXEN, [2] loopback (RX fed from TX internally), [3] TX FIFO flush (self-clearing), [4] RX FIFO flush (self-clearing).
  - 0x0C BAUD: DIV[DIV_W-1:0]; DIV < 3 is clamped to 3.
  - 0x10 IRQ: [2:0] enables for RX nonempty, TX empty, any error; write with PWDATA[8]=1 clears sticky bits [7:5] of STATUS.
- Transfers commit on PSEL & PENABLE; reads of DATA pop once per access.
- IRQ = (en0 & RXNE) | (en1 & TXE & TXEN) | (en2 & (FE|OVR|TXOVF)), registered.
- TX FSM IDLE→START→DATA(8 bits, LSB first)→STOP→IDLE/START. IDLE leaves when TXEN & FIFO nonempty, popping head. Each state bit lasts DIV+1 cycles. Clearing TXEN mid-frame completes the current frame.
- RX path: 2-flop synchroniser (reset to 1). RX FSM IDLE→START→DATA→STOP. Falling edge in IDLE (RXEN=1) starts counter at DIV/2; at expiry line must still be 0 else back to IDLE (glitch reject). Then sample every DIV+1 cycles: 8 data bits, then stop bit. Stop=0: set FE, discard byte. Stop=1 and FIFO full: set OVR, discard. Otherwise push.
- Simultaneous push and pop on full or empty FIFO: both succeed when legal (pop from full + push = stays full; push to empty + pop sees empty, pop ignored).
- BAUD write takes effect at next bit boundary of each FSM.

## Timing
- Reset values: TX=1, IRQ=0, PSLVERR=0, PRDATA=0, FIFOs empty, FSMs IDLE, CTRL=0, IRQ enables=0, sticky flags 0, DIV=DIV_RESET.
- PRDATA combinational from registers/FIFO head in access phase; PSLVERR combinational.
- TX start bit drives TX 2 cycles after the DATA-write access cycle when idle and TXEN=1.
- Frame length exactly 10·(DIV+1) cycles; back-to-back frames with no idle gap.
- RX byte visible (STATUS[2]=1) 1 cycle after stop sample; stop sampled at ~9.5 bit periods + 2 sync cycles after falling edge.
- PRESET asserted mid-frame: TX returns high next cycle, partial RX byte lost.

## Test plan
- Reset: hold PRESET 3 cycles → TX=1, IRQ=0, STATUS=0x01, BAUD reads 433.
- DIV=3, TXEN=1, write 0xA5 → TX: 0 then bits 1,0,1,0,0,1,0,1, then 1, each 4 cycles, 40 cycles total.
- Loopback, TXEN=RXEN=1, DIV=7, write 0x3C,0xC3 → RX FIFO holds 0x3C then 0xC3; IRQ with en0 asserts after first stop.
- Write TX_DEPTH+1 bytes with TXEN=0 → STATUS[1]=1, STATUS[7]=1; extra byte never sent.
- Drive RX frames with stop=0 → FE set, no push; RX_DEPTH+1 valid frames without reads → OVR set, first RX_DEPTH bytes intact.
- 1-bit-period/4 low glitch on RX → no push, FSM back to IDLE; unmapped address 0x14 → PSLVERR=1, PRDATA=0.
